// File: rtl/vga_tile_renderer.sv
// VGA raster timing generator with a two-stage tile-map pixel pipeline.
// Optional build macro: VGA_TILE_BORDER_EN (grid-dot separator on apple/head/body tiles).
module vga_tile_renderer #(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter int unsigned TILE_LOG2 = 4,
    parameter int unsigned TX_W      = 6,
    parameter int unsigned TY_W      = 5,
    parameter int unsigned COLOR_W   = 3,
    parameter logic [COLOR_W-1:0] HEAD_COLOR  = COLOR_W'(3'b010),
    parameter logic [COLOR_W-1:0] BODY_COLOR  = COLOR_W'(3'b011),
    parameter logic [COLOR_W-1:0] WALL_COLOR  = COLOR_W'(3'b101),
    parameter logic [COLOR_W-1:0] APPLE_COLOR = COLOR_W'(3'b001)
) (
    input  logic               clk,
    input  logic               reset,
    output logic [TX_W-1:0]    tile_x,
    output logic [TY_W-1:0]    tile_y,
    input  logic [1:0]         tile_type,
    input  logic [TX_W-1:0]    apple_x,
    input  logic [TY_W-1:0]    apple_y,
    output logic               h_sync,
    output logic               v_sync,
    output logic               de,
    output logic [COLOR_W-1:0] color_out,
    output logic               frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HCW     = $clog2(H_TOTAL);
    localparam int unsigned VCW     = $clog2(V_TOTAL);
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam int unsigned H_SYNC_LO = H_ACTIVE + H_FP;
    localparam int unsigned H_SYNC_HI = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned V_SYNC_LO = V_ACTIVE + V_FP;
    localparam int unsigned V_SYNC_HI = V_ACTIVE + V_FP + V_SYNC;

    localparam logic [1:0] TILE_NONE = 2'b00;
    localparam logic [1:0] TILE_HEAD = 2'b01;
    localparam logic [1:0] TILE_BODY = 2'b10;
    localparam logic [1:0] TILE_WALL = 2'b11;

    logic [DIV_W-1:0] div_cnt;
    logic             pix_ce;
    logic [HCW-1:0]   h_cnt;
    logic [VCW-1:0]   v_cnt;
    logic             h_last;
    logic             v_last;

    // Raster decode of the current counter position
    logic             h_act;
    logic             v_act;
    logic             h_sync_raw;
    logic             v_sync_raw;
    logic [TX_W-1:0]  tx_cur;
    logic [TY_W-1:0]  ty_cur;
    logic             apple_hit;

    // Stage-1 registers, aligned with the tile request on tile_x/tile_y
    logic             s1_active;
    logic             s1_apple;
    logic             s1_hs;
    logic             s1_vs;
    logic             s1_first;
`ifdef VGA_TILE_BORDER_EN
    logic [TILE_LOG2-1:0] s1_lox;
    logic [TILE_LOG2-1:0] s1_loy;
`endif

    logic [COLOR_W-1:0] color_nxt;

    // Pixel-clock enable: one system clock in every CLK_DIV
    assign pix_ce = (32'(div_cnt) == CLK_DIV - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (pix_ce) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign h_last = (32'(h_cnt) == H_TOTAL - 1);
    assign v_last = (32'(v_cnt) == V_TOTAL - 1);

    // Horizontal and vertical raster counters
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_ce) begin
            if (h_last) begin
                h_cnt <= '0;
                if (v_last) begin
                    v_cnt <= '0;
                end else begin
                    v_cnt <= v_cnt + VCW'(1);
                end
            end else begin
                h_cnt <= h_cnt + HCW'(1);
            end
        end
    end

    always_comb begin
        h_act      = (32'(h_cnt) < H_ACTIVE);
        v_act      = (32'(v_cnt) < V_ACTIVE);
        h_sync_raw = !((32'(h_cnt) >= H_SYNC_LO) && (32'(h_cnt) < H_SYNC_HI));
        v_sync_raw = !((32'(v_cnt) >= V_SYNC_LO) && (32'(v_cnt) < V_SYNC_HI));
        tx_cur     = TX_W'(h_cnt >> TILE_LOG2);
        ty_cur     = TY_W'(v_cnt >> TILE_LOG2);
        apple_hit  = (tx_cur == apple_x) && (ty_cur == apple_y);
    end

    // Stage 1: issue the tile request and carry the pixel attributes alongside it
    always_ff @(posedge clk) begin
        if (reset) begin
            tile_x    <= '0;
            tile_y    <= '0;
            s1_active <= 1'b0;
            s1_apple  <= 1'b0;
            s1_hs     <= 1'b1;
            s1_vs     <= 1'b1;
            s1_first  <= 1'b0;
        end else if (pix_ce) begin
            tile_x    <= tx_cur;
            tile_y    <= ty_cur;
            s1_active <= h_act && v_act;
            s1_apple  <= apple_hit;
            s1_hs     <= h_sync_raw;
            s1_vs     <= v_sync_raw;
            s1_first  <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

`ifdef VGA_TILE_BORDER_EN
    // Sub-tile offset, only needed for the grid-dot separator
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_lox <= '0;
            s1_loy <= '0;
        end else if (pix_ce) begin
            s1_lox <= h_cnt[TILE_LOG2-1:0];
            s1_loy <= v_cnt[TILE_LOG2-1:0];
        end
    end
`endif

    // Palette lookup: blanking, then apple, then tile content
    always_comb begin
        color_nxt = '0;
        if (s1_active) begin
            if (s1_apple) begin
                color_nxt = APPLE_COLOR;
            end else begin
                case (tile_type)
                    TILE_WALL: color_nxt = WALL_COLOR;
                    TILE_HEAD: color_nxt = HEAD_COLOR;
                    TILE_BODY: color_nxt = BODY_COLOR;
                    TILE_NONE: color_nxt = '0;
                    default:   color_nxt = '0;
                endcase
            end
`ifdef VGA_TILE_BORDER_EN
            if ((s1_lox == '0) && (s1_loy == '0) &&
                (s1_apple || (tile_type == TILE_HEAD) || (tile_type == TILE_BODY))) begin
                color_nxt = '0;
            end
`endif
        end
    end

    // Stage 2: registered pixel outputs, all sharing the same latency
    always_ff @(posedge clk) begin
        if (reset) begin
            h_sync    <= 1'b1;
            v_sync    <= 1'b1;
            de        <= 1'b0;
            color_out <= '0;
        end else if (pix_ce) begin
            h_sync    <= s1_hs;
            v_sync    <= s1_vs;
            de        <= s1_active;
            color_out <= color_nxt;
        end
    end

    // Single-clock marker on the cycle pixel (0,0) reaches the outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_ce && s1_first;
        end
    end

endmodule

// File: tb/tb_vga_tile_renderer.sv
// Directed bench for vga_tile_renderer on a reduced raster; pixel probes are table-driven.
module tb_vga_tile_renderer;

    localparam int CD  = 2;
    localparam int HA  = 96;
    localparam int HFP = 2;
    localparam int HS  = 4;
    localparam int HBP = 2;
    localparam int VA  = 96;
    localparam int VFP = 1;
    localparam int VS  = 2;
    localparam int VBP = 1;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;
    localparam int FT  = HT * VT;
    localparam int NV  = 25;

`ifdef VGA_TILE_BORDER_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif

    typedef struct {
        int         frame;
        int         x;
        int         y;
        logic       de;
        logic [2:0] color;
    } vec_t;

    logic       clk;
    logic       reset;
    logic [5:0] tile_x;
    logic [4:0] tile_y;
    logic [1:0] tile_type;
    logic [5:0] apple_x;
    logic [4:0] apple_y;
    logic       h_sync;
    logic       v_sync;
    logic       de;
    logic [2:0] color_out;
    logic       frame_start;

    int   cyc;
    int   checks;
    int   failures;
    bit   phase1;
    bit   mon_en;
    vec_t vecs[NV];
    int   nvec;

    int hs_fall0 = -1, hs_fall1 = -1, hs_rise0 = -1, hs_nf = 0, hs_nr = 0;
    int vs_fall0 = -1, vs_fall1 = -1, vs_rise0 = -1, vs_nf = 0, vs_nr = 0;
    int fs_cyc0 = -1, fs_cyc1 = -1, fs_n = 0;
    int de_rise0 = -1, de_nr = 0, bad_dc = 0;

    vga_tile_renderer #(
        .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .TILE_LOG2(4), .TX_W(6), .TY_W(5), .COLOR_W(3)
    ) dut (
        .clk(clk), .reset(reset), .tile_x(tile_x), .tile_y(tile_y),
        .tile_type(tile_type), .apple_x(apple_x), .apple_y(apple_y),
        .h_sync(h_sync), .v_sync(v_sync), .de(de), .color_out(color_out),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since reset release
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    function automatic logic [1:0] tile_at(input logic [5:0] tx, input logic [4:0] ty, input bit ph);
        if (tx == 6'd0 && ty == 5'd0) return 2'b01;
        if (tx == 6'd1 && ty == 5'd0) return 2'b10;
        if (tx == 6'd2 && ty == 5'd0) return 2'b11;
        if (tx == 6'd3 && ty == 5'd2) return ph ? 2'b11 : 2'b01;
        return 2'b00;
    endfunction

    // Tile store model with one system clock of read latency
    always @(posedge clk) tile_type <= tile_at(tile_x, tile_y, phase1);

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic add(input int f, input int x, input int y, input logic d, input logic [2:0] c);
        vecs[nvec].frame = f;
        vecs[nvec].x     = x;
        vecs[nvec].y     = y;
        vecs[nvec].de    = d;
        vecs[nvec].color = c;
        nvec++;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_tile_x"}, int'(tile_x), 0);
        chk({tag, "_tile_y"}, int'(tile_y), 0);
        chk({tag, "_h_sync"}, int'(h_sync), 1);
        chk({tag, "_v_sync"}, int'(v_sync), 1);
        chk({tag, "_de"}, int'(de), 0);
        chk({tag, "_color"}, int'(color_out), 0);
        chk({tag, "_frame_start"}, int'(frame_start), 0);
    endtask

    // Edge monitor over the first two frames after release
    initial begin
        bit p_hs, p_vs, p_de;
        p_hs = 1'b1; p_vs = 1'b1; p_de = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (p_hs && !h_sync) begin
                    if (hs_nf == 0) hs_fall0 = cyc;
                    if (hs_nf == 1) hs_fall1 = cyc;
                    hs_nf++;
                end
                if (!p_hs && h_sync && hs_nr == 0) begin hs_rise0 = cyc; hs_nr++; end
                if (p_vs && !v_sync) begin
                    if (vs_nf == 0) vs_fall0 = cyc;
                    if (vs_nf == 1) vs_fall1 = cyc;
                    vs_nf++;
                end
                if (!p_vs && v_sync && vs_nr == 0) begin vs_rise0 = cyc; vs_nr++; end
                if (!p_de && de && de_nr == 0) begin de_rise0 = cyc; de_nr++; end
                if (frame_start) begin
                    if (fs_n == 0) fs_cyc0 = cyc;
                    if (fs_n == 1) fs_cyc1 = cyc;
                    fs_n++;
                end
                if (!de && color_out != 3'd0) bad_dc++;
                p_hs = h_sync; p_vs = v_sync; p_de = de;
            end
        end
    end

    initial begin
        int target;
        int fall;
        checks = 0; failures = 0; nvec = 0;
        reset = 1'b1; phase1 = 1'b0; mon_en = 1'b0;
        apple_x = 6'd5; apple_y = 5'd5;

        // frame 0: apple (5,5); head (0,0), body (1,0), wall (2,0), head (3,2)
        add(0,  0,  0, 1'b1, BORDER ? 3'b000 : 3'b010);
        add(0,  1,  0, 1'b1, 3'b010);
        add(0, 15,  0, 1'b1, 3'b010);
        add(0, 16,  0, 1'b1, BORDER ? 3'b000 : 3'b011);
        add(0, 17,  0, 1'b1, 3'b011);
        add(0, 32,  0, 1'b1, 3'b101);
        add(0, 47,  0, 1'b1, 3'b101);
        add(0, 48,  0, 1'b1, 3'b000);
        add(0, 95,  0, 1'b1, 3'b000);
        add(0, 96,  0, 1'b0, 3'b000);
        add(0, 47, 32, 1'b1, 3'b000);
        add(0, 48, 32, 1'b1, BORDER ? 3'b000 : 3'b010);
        add(0, 49, 32, 1'b1, 3'b010);
        add(0, 63, 47, 1'b1, 3'b010);
        add(0, 64, 47, 1'b1, 3'b000);
        add(0, 48, 48, 1'b1, 3'b000);
        add(0, 80, 80, 1'b1, BORDER ? 3'b000 : 3'b001);
        add(0, 95, 95, 1'b1, 3'b001);
        add(0, 96, 95, 1'b0, 3'b000);
        add(0,  0, 97, 1'b0, 3'b000);
        // frame 1: apple moved onto (3,2), which is now a wall
        add(1,  1,  0, 1'b1, 3'b010);
        add(1, 32,  0, 1'b1, 3'b101);
        add(1, 48, 32, 1'b1, BORDER ? 3'b000 : 3'b001);
        add(1, 50, 33, 1'b1, 3'b001);
        add(1, 80, 80, 1'b1, 3'b000);

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("rst_hold");
        reset = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < nvec; i++) begin
            if (vecs[i].frame == 1 && !phase1) begin
                phase1 = 1'b1;
                apple_x = 6'd3;
                apple_y = 5'd2;
            end
            target = CD * (vecs[i].frame * FT + vecs[i].y * HT + vecs[i].x + 2);
            while (cyc < target) @(negedge clk);
            chk($sformatf("px_de_f%0d_x%0d_y%0d", vecs[i].frame, vecs[i].x, vecs[i].y),
                int'(de), int'(vecs[i].de));
            chk($sformatf("px_color_f%0d_x%0d_y%0d", vecs[i].frame, vecs[i].x, vecs[i].y),
                int'(color_out), int'(vecs[i].color));
        end

        while (cyc < 2 * FT * CD) @(negedge clk);
        mon_en = 1'b0;

        chk("hs_first_fall", hs_fall0, CD * (HA + HFP + 2));
        chk("hs_low_len", hs_rise0 - hs_fall0, HS * CD);
        chk("line_period", hs_fall1 - hs_fall0, HT * CD);
        chk("vs_first_fall", vs_fall0, CD * ((VA + VFP) * HT + 2));
        chk("vs_low_len", vs_rise0 - vs_fall0, VS * HT * CD);
        chk("frame_period_vs", vs_fall1 - vs_fall0, FT * CD);
        chk("vs_falls_2frames", vs_nf, 2);
        chk("fs_count", fs_n, 2);
        chk("fs_first", fs_cyc0, CD * 2);
        chk("de_first_rise", de_rise0, CD * 2);
        chk("frame_period_fs", fs_cyc1 - fs_cyc0, FT * CD);
        chk("de0_color_nonzero", bad_dc, 0);

        // Reset pulsed in the middle of line 0 of frame 2
        phase1 = 1'b0;
        apple_x = 6'd5; apple_y = 5'd5;
        target = CD * (2 * FT + 60);
        while (cyc < target) @(negedge clk);
        chk("mid_de_before", int'(de), 1);
        chk("mid_tile_x_before", int'(tile_x), 3);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_vals("rst_mid");
        reset = 1'b0;
        fall = -1;
        for (int k = 0; k < 4 * HT * CD && fall < 0; k++) begin
            @(negedge clk);
            if (!h_sync) fall = cyc;
        end
        chk("restart_hs_fall", fall, CD * (HA + HFP + 2));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
